// File: rtl/div_tc_32_16.sv
// Sequential signed divider: 32-bit dividend / 16-bit divisor, one quotient bit per cycle.
// Optional macro DIV_ZERO_BYPASS_EN: a zero divisor skips the iteration phase.
module div_tc_32_16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] dividend,
  input  logic [15:0] divisor,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] quotient,
  output logic [15:0] remainder,
  output logic        err
);

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e      r_state;
  logic [31:0] r_q;
  logic [16:0] r_d;
  logic [16:0] r_prem;
  logic [4:0]  r_cnt;
  logic        r_sign_q;
  logic        r_sign_r;
  logic        r_dz;
  logic        r_ovf;
  logic [15:0] r_dvd_lo;
  logic        r_in_ready;
  logic        r_out_valid;
  logic [31:0] r_quotient;
  logic [15:0] r_remainder;
  logic        r_err;

  logic [31:0] w_dvd_mag;
  logic [16:0] w_dvs_mag;
  logic [17:0] w_shift;
  logic [17:0] w_d18;
  logic [17:0] w_trial;
  logic        w_qbit;
  logic [15:0] w_rem_mag;
  logic [31:0] w_q_signed;
  logic [15:0] w_r_signed;

  // |-2^31| stays 0x8000_0000 as an unsigned value; divisor magnitude needs 17 bits for -32768
  assign w_dvd_mag = dividend[31] ? (~dividend + 32'd1) : dividend;
  assign w_dvs_mag = divisor[15] ? (~{divisor[15], divisor} + 17'd1) : {1'b0, divisor};

  // Non-restoring step: shift in next dividend bit, add or subtract by sign of partial remainder
  assign w_shift = {r_prem, r_q[31]};
  assign w_d18   = {1'b0, r_d};
  assign w_trial = r_prem[16] ? (w_shift + w_d18) : (w_shift - w_d18);
  assign w_qbit  = ~w_trial[17];

  assign w_rem_mag  = r_prem[16] ? (r_prem[15:0] + r_d[15:0]) : r_prem[15:0];
  assign w_q_signed = r_sign_q ? (~r_q + 32'd1) : r_q;
  assign w_r_signed = r_sign_r ? (~w_rem_mag + 16'd1) : w_rem_mag;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_q         <= '0;
      r_d         <= '0;
      r_prem      <= '0;
      r_cnt       <= '0;
      r_sign_q    <= 1'b0;
      r_sign_r    <= 1'b0;
      r_dz        <= 1'b0;
      r_ovf       <= 1'b0;
      r_dvd_lo    <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_err       <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (in_valid) begin
            r_q        <= w_dvd_mag;
            r_d        <= w_dvs_mag;
            r_prem     <= '0;
            r_cnt      <= '0;
            r_sign_q   <= dividend[31] ^ divisor[15];
            r_sign_r   <= dividend[31];
            r_dz       <= (divisor == 16'h0000);
            r_ovf      <= (dividend == 32'h8000_0000) && (divisor == 16'hFFFF);
            r_dvd_lo   <= dividend[15:0];
            r_in_ready <= 1'b0;
`ifdef DIV_ZERO_BYPASS_EN
            r_state    <= (divisor == 16'h0000) ? StFix : StCalc;
`else
            r_state    <= StCalc;
`endif
          end
        end
        StCalc: begin
          r_prem <= w_trial[16:0];
          r_q    <= {r_q[30:0], w_qbit};
          r_cnt  <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) begin
            r_state <= StFix;
          end
        end
        StFix: begin
          if (r_dz) begin
            r_quotient  <= r_sign_r ? 32'h8000_0000 : 32'h7FFF_FFFF;
            r_remainder <= r_dvd_lo;
            r_err       <= 1'b1;
          end else if (r_ovf) begin
            r_quotient  <= 32'h7FFF_FFFF;
            r_remainder <= '0;
            r_err       <= 1'b1;
          end else begin
            r_quotient  <= w_q_signed;
            r_remainder <= w_r_signed;
            r_err       <= 1'b0;
          end
          r_out_valid <= 1'b1;
          r_state     <= StDone;
        end
        StDone: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign quotient  = r_quotient;
  assign remainder = r_remainder;
  assign err       = r_err;

endmodule

// File: tb/tb_div_tc_32_16.sv
// Scoreboard bench for div_tc_32_16: reference model, fixed latency, backpressure and reset.
module tb_div_tc_32_16;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] dividend;
  logic [15:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] quotient;
  logic [15:0] remainder;
  logic        err;

  typedef struct packed {
    logic [31:0] q;
    logic [15:0] r;
    logic        e;
    logic [7:0]  lat;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  div_tc_32_16 u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [15:0] b);
    exp_t m;
    logic signed [31:0] sa32;
    logic signed [15:0] sb16;
    longint la, lb, lq, lr;
    sa32 = a;
    sb16 = b;
    la = longint'(sa32);
    lb = longint'(sb16);
    m.lat = 8'd34;
    if (lb == 0) begin
      m.q = (la >= 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
      m.r = a[15:0];
      m.e = 1'b1;
`ifdef DIV_ZERO_BYPASS_EN
      m.lat = 8'd2;
`endif
    end else if (la == -64'sd2147483648 && lb == -1) begin
      m.q = 32'h7FFF_FFFF;
      m.r = 16'h0000;
      m.e = 1'b1;
    end else begin
      lq  = la / lb;
      lr  = la % lb;
      m.q = lq[31:0];
      m.r = lr[15:0];
      m.e = 1'b0;
    end
    return m;
  endfunction

  // Leaves the bench 1 time unit after the acceptance edge with in_valid optionally dropped
  task automatic accept(input logic [31:0] a, input logic [15:0] b, input bit hold_valid);
    int n = 0;
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("accept_ready", in_ready, 1);
    @(posedge clk);
    sb.push_back(model(a, b));
    #1;
    if (!hold_valid) in_valid = 1'b0;
    check("busy_after_accept", in_ready, 0);
  endtask

  task automatic wait_result(input string tag, output exp_t e);
    int n = 0;
    while (!out_valid && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    e = sb.pop_front();
    check({tag, "_lat"}, n + 1, e.lat);
    check({tag, "_q"}, quotient, e.q);
    check({tag, "_r"}, remainder, e.r);
    check({tag, "_err"}, err, e.e);
  endtask

  task automatic complete(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_ov_low"}, out_valid, 0);
    check({tag, "_ready"}, in_ready, 1);
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [15:0] b);
    exp_t e;
    accept(a, b, 1'b0);
    wait_result(tag, e);
    complete(tag);
  endtask

  initial begin
    exp_t e;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_q", quotient, 0);
    check("rst_r", remainder, 0);
    check("rst_err", err, 0);
    rst = 1'b0;

    run_op("p100_7", 32'd100, 16'd7);
    run_op("n100_7", -32'sd100, 16'd7);
    run_op("p100_n7", 32'd100, -16'sd7);
    run_op("min_m1", 32'h8000_0000, 16'hFFFF);
    run_op("min_min16", 32'h8000_0000, 16'h8000);
    run_op("div0_pos", 32'd1234, 16'd0);
    run_op("div0_neg", -32'sd5, 16'd0);
    run_op("min_p1", 32'h8000_0000, 16'd1);

    // Backpressure: result must hold while in_valid is already high for the next op
    accept(32'd50000, 16'd123, 1'b0);
    wait_result("bp", e);
    dividend = 32'd100;
    divisor  = 16'd7;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_hold_ov", out_valid, 1);
      check("bp_hold_q", quotient, e.q);
      check("bp_hold_r", remainder, e.r);
      check("bp_hold_busy", in_ready, 0);
    end
    complete("bp");
    @(posedge clk);
    sb.push_back(model(32'd100, 16'd7));
    #1;
    in_valid = 1'b0;
    check("bp_next_busy", in_ready, 0);
    wait_result("bp_next", e);
    complete("bp_next");

    // Reset mid-calculation discards the operation
    accept(32'd100, 16'd7, 1'b0);
    repeat (14) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    check("mid_rst_ready", in_ready, 1);
    check("mid_rst_ov", out_valid, 0);
    check("mid_rst_q", quotient, 0);
    run_op("after_rst", 32'd100, 16'd7);

    for (int i = 0; i < 8; i++) begin
      logic [31:0] ra;
      logic [15:0] rb;
      ra = $urandom;
      rb = $urandom;
      if (i == 0) rb = 16'h0001;
      if (i == 1) rb = 16'h7FFF;
      run_op("rand", ra, rb);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
